// File: rtl/inst_fetch.sv
// inst_fetch -- instruction fetch stage with a single outstanding memory
// transaction and MIPS-style branch delay slot handling.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   stall                 ID is not accepting the presented instruction
//   pcsource              redirect select for the instruction in ID
//                         (00 seq, 01 bpc, 10 jrpc, 11 jpc)
//   bpc, jpc, jrpc        redirect targets from ID
//   inst_req, inst_addr   instruction-memory request (registered outputs)
//   inst_addr_ok          memory accepted the request
//   inst_data_ok          inst_rdata valid
//   inst_rdata            returned instruction word
//   o_valid, o_inst, o_pc fetched instruction and its address for ID
module inst_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] jrpc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc
);

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        inst_req_q, inst_req_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        o_valid_q, o_valid_d;
  logic [31:0] o_inst_q, o_inst_d;
  logic [31:0] o_pc_q, o_pc_d;
  logic        redirect_pending_q, redirect_pending_d;
  logic [31:0] redirect_target_q, redirect_target_d;
  logic [31:0] sel_target;

  // Target chosen by ID's redirect select; only meaningful when pcsource != 00.
  always_comb begin
    sel_target = jpc;
    case (pcsource)
      2'b01:   sel_target = bpc;
      2'b10:   sel_target = jrpc;
      default: sel_target = jpc;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    inst_req_d         = inst_req_q;
    inst_addr_d        = inst_addr_q;
    fetch_pc_d         = fetch_pc_q;
    o_valid_d          = o_valid_q;
    o_inst_d           = o_inst_q;
    o_pc_d             = o_pc_q;
    redirect_pending_d = redirect_pending_q;
    redirect_target_d  = redirect_target_q;

    case (state_q)
      IDLE: begin
        state_d     = REQ;
        inst_req_d  = 1'b1;
        inst_addr_d = RESET_PC;
      end
      REQ: begin
        if (inst_addr_ok) begin
          fetch_pc_d = inst_addr_q;
          inst_req_d = 1'b0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (inst_data_ok) begin
          o_inst_d  = inst_rdata;
          o_pc_d    = fetch_pc_q;
          o_valid_d = 1'b1;
          state_d   = VALID;
        end
      end
      VALID: begin
        if (!stall) begin
          o_valid_d  = 1'b0;
          inst_req_d = 1'b1;
          state_d    = REQ;
          if (redirect_pending_q) begin
            // This was the delay slot: go to the saved target and ignore
            // any redirect carried by the delay-slot instruction itself.
            inst_addr_d        = redirect_target_q;
            redirect_pending_d = 1'b0;
          end else begin
            inst_addr_d = o_pc_q + 32'd4;
            if (pcsource != 2'b00) begin
              redirect_pending_d = 1'b1;
              redirect_target_d  = sel_target;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= IDLE;
      inst_req_q         <= 1'b0;
      inst_addr_q        <= RESET_PC;
      fetch_pc_q         <= 32'd0;
      o_valid_q          <= 1'b0;
      o_inst_q           <= 32'd0;
      o_pc_q             <= 32'd0;
      redirect_pending_q <= 1'b0;
      redirect_target_q  <= 32'd0;
    end else begin
      state_q            <= state_d;
      inst_req_q         <= inst_req_d;
      inst_addr_q        <= inst_addr_d;
      fetch_pc_q         <= fetch_pc_d;
      o_valid_q          <= o_valid_d;
      o_inst_q           <= o_inst_d;
      o_pc_q             <= o_pc_d;
      redirect_pending_q <= redirect_pending_d;
      redirect_target_q  <= redirect_target_d;
    end
  end

  assign inst_req  = inst_req_q;
  assign inst_addr = inst_addr_q;
  assign o_valid   = o_valid_q;
  assign o_inst    = o_inst_q;
  assign o_pc      = o_pc_q;

endmodule
